// File: rtl/scan_llr_pingpong_store.sv
// Ping-pong channel-LLR store: two N-LLR frame banks, one filled from the channel
// while the decoder reads the other, with frame handshakes and a sticky protocol-error flag.
//
// bank state | meaning
// EMPTY      | no valid data; may be written from index 0
// FILL       | partially loaded frame
// FULL       | complete frame waiting for the decoder to claim it
// DECODE     | claimed by the decoder; readable, awaiting release
module scan_llr_pingpong_store #(
  parameter  int N  = 1024,
  parameter  int P  = 128,
  parameter  int Q  = 6,
  localparam int B  = N / P,
  localparam int CW = (B > 1) ? $clog2(B) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [P*Q-1:0] in_data,
  output logic          frame_ready,
  input  logic          frame_start,
  input  logic          frame_done,
  input  logic          rd_en,
  input  logic [CW-1:0] rd_counter,
  output logic [P*Q-1:0] rd_data,
  output logic          busy,
  output logic          wr_bank,
  output logic          rd_bank,
  output logic          protocol_err
);

  typedef enum logic [1:0] {EMPTY, FILL, FULL, DECODE} bank_state_t;

  // Depth rounded to 2**CW so the B = 1 case still has a legal 1-bit index.
  localparam int D = 1 << CW;

  logic [P*Q-1:0] mem [2][D];

  bank_state_t   state_q [2];
  bank_state_t   state_d [2];
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          wr_bank_d, rd_bank_d, err_d;

  logic wr_fire, wr_last, start_ok, done_ok, rd_ok, err_ev;

  assign in_ready    = !rst && (state_q[wr_bank] == EMPTY || state_q[wr_bank] == FILL);
  assign frame_ready = (state_q[rd_bank] == FULL);
  assign busy        = (state_q[rd_bank] == DECODE);

  assign wr_fire  = in_valid && in_ready;
  assign wr_last  = (wcnt_q == CW'(B - 1));
  assign start_ok = frame_start && frame_ready && !frame_done;
  assign done_ok  = frame_done && busy && !frame_start;
  assign rd_ok    = rd_en && busy;
  assign err_ev   = (frame_start && !frame_ready) || (frame_done && !busy) ||
                    (rd_en && !busy) || (frame_start && frame_done);

  // Write and read sides can never target the same bank in one cycle:
  // writes need EMPTY/FILL, claim needs FULL, release needs DECODE.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    wr_bank_d = wr_bank;
    rd_bank_d = rd_bank;
    err_d     = protocol_err | err_ev;
    if (wr_fire) begin
      state_d[wr_bank] = wr_last ? FULL : FILL;
      wcnt_d           = wr_last ? '0 : wcnt_q + CW'(1);
      if (wr_last) wr_bank_d = ~wr_bank;
    end
    if (start_ok) state_d[rd_bank] = DECODE;
    if (done_ok) begin
      state_d[rd_bank] = EMPTY;
      rd_bank_d        = ~rd_bank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q[0]   <= EMPTY;
      state_q[1]   <= EMPTY;
      wcnt_q       <= '0;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      wr_bank      <= wr_bank_d;
      rd_bank      <= rd_bank_d;
      protocol_err <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else if (rd_ok) rd_data <= mem[rd_bank][rd_counter];
  end

  // Frame storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank][wcnt_q] <= in_data;
  end

endmodule

// File: tb/tb_scan_llr_pingpong_store.sv
// Scoreboard bench for scan_llr_pingpong_store: default build plus B=1 and
// N=256/P=32/Q=5 builds, with read data checked by a decoupled monitor.
module tb_scan_llr_pingpong_store;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // default build: B = 8, CW = 3, 768-bit beats
  logic iv0 = 0, fs0 = 0, fd0 = 0, re0 = 0;
  logic [767:0] id0 = '0, rdd0;
  logic [2:0] rc0 = '0;
  logic ir0, fr0, busy0, wb0, rb0, pe0;

  // B = 1 build
  logic iv1 = 0, fs1 = 0, fd1 = 0, re1 = 0;
  logic [767:0] id1 = '0, rdd1;
  logic [0:0] rc1 = '0;
  logic ir1, fr1, busy1, wb1, rb1, pe1;

  // N=256, P=32, Q=5 build
  logic iv2 = 0, fs2 = 0, fd2 = 0, re2 = 0;
  logic [159:0] id2 = '0, rdd2;
  logic [2:0] rc2 = '0;
  logic ir2, fr2, busy2, wb2, rb2, pe2;

  scan_llr_pingpong_store dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .frame_ready(fr0), .frame_start(fs0), .frame_done(fd0), .rd_en(re0),
    .rd_counter(rc0), .rd_data(rdd0), .busy(busy0), .wr_bank(wb0),
    .rd_bank(rb0), .protocol_err(pe0));

  scan_llr_pingpong_store #(.N(128), .P(128), .Q(6)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .frame_ready(fr1), .frame_start(fs1), .frame_done(fd1), .rd_en(re1),
    .rd_counter(rc1), .rd_data(rdd1), .busy(busy1), .wr_bank(wb1),
    .rd_bank(rb1), .protocol_err(pe1));

  scan_llr_pingpong_store #(.N(256), .P(32), .Q(5)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .frame_ready(fr2), .frame_start(fs2), .frame_done(fd2), .rd_en(re2),
    .rd_counter(rc2), .rd_data(rdd2), .busy(busy2), .wr_bank(wb2),
    .rd_bank(rb2), .protocol_err(pe2));

  logic [767:0] exp_q0 [$];
  logic [767:0] exp_q1 [$];
  logic [159:0] exp_q2 [$];
  logic req0 = 0, req1 = 0, req2 = 0;
  logic pend0 = 0, pend1 = 0, pend2 = 0;

  task automatic chk(input string name, input logic [767:0] act, input logic [767:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic underflow(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: rd_data presented with no expected entry", name);
  endtask

  // A read issued at edge t must show its word from edge t onward; compare at the next negedge.
  always @(posedge clk) begin
    pend0 <= req0;
    pend1 <= req1;
    pend2 <= req2;
  end

  always @(negedge clk) begin
    if (pend0) begin
      if (exp_q0.size() == 0) underflow("rd_data0");
      else chk("rd_data0", rdd0, exp_q0.pop_front());
    end
    if (pend1) begin
      if (exp_q1.size() == 0) underflow("rd_data1");
      else chk("rd_data1", rdd1, exp_q1.pop_front());
    end
    if (pend2) begin
      if (exp_q2.size() == 0) underflow("rd_data2");
      else chk("rd_data2", {608'b0, rdd2}, {608'b0, exp_q2.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat0(input logic [5:0] v);
    iv0 = 1; id0 = {128{v}}; tick(); iv0 = 0;
  endtask
  task automatic read0(input int c, input logic [5:0] v);
    re0 = 1; rc0 = 3'(c); req0 = 1; exp_q0.push_back({128{v}});
    tick(); re0 = 0; req0 = 0;
  endtask
  task automatic start0(); fs0 = 1; tick(); fs0 = 0; endtask
  task automatic done0();  fd0 = 1; tick(); fd0 = 0; endtask

  task automatic beat1(input logic [5:0] v);
    iv1 = 1; id1 = {128{v}}; tick(); iv1 = 0;
  endtask
  task automatic read1(input logic [5:0] v);
    re1 = 1; rc1 = 1'b0; req1 = 1; exp_q1.push_back({128{v}});
    tick(); re1 = 0; req1 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    // reset state
    #2;
    chk("rst_in_ready", ir0, 0);
    chk("rst_frame_ready", fr0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_wr_bank", wb0, 0);
    chk("rst_rd_bank", rb0, 0);
    chk("rst_rd_data", rdd0, 0);
    chk("rst_protocol_err", pe0, 0);
    tick(); tick();
    rst = 0;
    tick();
    chk("post_rst_in_ready", ir0, 1);

    // single frame into bank 0, claim, read back
    for (int i = 0; i < 8; i++) beat0(6'(i));
    chk("t1_frame_ready", fr0, 1);
    chk("t1_wr_bank", wb0, 1);
    chk("t1_in_ready", ir0, 1);
    chk("t1_busy_pre", busy0, 0);
    start0();
    chk("t1_busy", busy0, 1);
    chk("t1_frame_ready_claimed", fr0, 0);
    for (int c = 0; c < 8; c++) read0(c, 6'(c));

    // second frame into bank 1 while bank 0 is decoding; both banks then occupied
    for (int i = 0; i < 8; i++) beat0(6'(8 + i));
    chk("t2_in_ready_full", ir0, 0);
    chk("t2_wr_bank", wb0, 0);
    chk("t2_frame_ready", fr0, 0);
    beat0(6'd63);
    chk("t2_wr_bank_hold", wb0, 0);
    done0();
    chk("t2_rd_bank", rb0, 1);
    chk("t2_frame_ready_after_done", fr0, 1);
    chk("t2_in_ready_after_done", ir0, 1);
    chk("t2_busy_after_done", busy0, 0);

    // last beat into bank 0 in the same cycle as the release of bank 1
    start0();
    read0(7, 6'd15);
    read0(0, 6'd8);
    for (int i = 0; i < 7; i++) beat0(6'(20 + i));
    iv0 = 1; id0 = {128{6'd27}}; fd0 = 1;
    tick();
    iv0 = 0; fd0 = 0;
    chk("t3_rd_bank", rb0, 0);
    chk("t3_wr_bank", wb0, 1);
    chk("t3_frame_ready", fr0, 1);
    chk("t3_in_ready", ir0, 1);
    chk("t3_protocol_err", pe0, 0);
    start0();
    for (int c = 0; c < 8; c++) read0(c, 6'(20 + c));
    done0();

    // frame_start with nothing full
    start0();
    chk("t4_protocol_err", pe0, 1);
    chk("t4_busy", busy0, 0);
    chk("t4_frame_ready", fr0, 0);
    for (int i = 0; i < 8; i++) beat0(6'(30 + i));
    chk("t4_frame_ready_later", fr0, 1);
    start0();
    read0(3, 6'd33);
    read0(5, 6'd35);
    chk("t4_protocol_err_sticky", pe0, 1);
    done0();

    // reset mid-frame
    for (int i = 0; i < 5; i++) beat0(6'(50 + i));
    rst = 1;
    #1;
    chk("t5_in_ready", ir0, 0);
    chk("t5_frame_ready", fr0, 0);
    chk("t5_busy", busy0, 0);
    chk("t5_wr_bank", wb0, 0);
    chk("t5_rd_bank", rb0, 0);
    chk("t5_rd_data", rdd0, 0);
    chk("t5_protocol_err", pe0, 0);
    tick();
    rst = 0;
    for (int i = 0; i < 8; i++) beat0(6'(40 + i));
    chk("t5_wr_bank_after", wb0, 1);
    chk("t5_frame_ready_after", fr0, 1);
    start0();
    for (int c = 0; c < 8; c++) read0(c, 6'(40 + c));
    done0();

    // B = 1: every beat is a full frame
    beat1(6'd11);
    chk("b1_frame_ready", fr1, 1);
    chk("b1_wr_bank", wb1, 1);
    chk("b1_in_ready", ir1, 1);
    beat1(6'd12);
    chk("b1_in_ready_full", ir1, 0);
    chk("b1_wr_bank_wrap", wb1, 0);
    fs1 = 1; tick(); fs1 = 0;
    read1(6'd11);
    fd1 = 1; tick(); fd1 = 0;
    chk("b1_rd_bank", rb1, 1);
    chk("b1_frame_ready_second", fr1, 1);
    chk("b1_in_ready_released", ir1, 1);
    fs1 = 1; tick(); fs1 = 0;
    read1(6'd12);
    fd1 = 1; tick(); fd1 = 0;
    chk("b1_rd_bank_back", rb1, 0);
    chk("b1_protocol_err_clean", pe1, 0);
    re1 = 1; tick(); re1 = 0;
    chk("b1_rd_en_idle_err", pe1, 1);
    chk("b1_busy_idle", busy1, 0);

    // N=256, P=32, Q=5
    for (int i = 0; i < 8; i++) begin
      iv2 = 1; id2 = {32{5'(i + 3)}}; tick();
    end
    iv2 = 0;
    chk("q5_frame_ready", fr2, 1);
    chk("q5_wr_bank", wb2, 1);
    fs2 = 1; fd2 = 1; tick(); fs2 = 0; fd2 = 0;
    chk("q5_start_done_err", pe2, 1);
    chk("q5_busy_ignored", busy2, 0);
    chk("q5_frame_ready_kept", fr2, 1);
    fs2 = 1; tick(); fs2 = 0;
    chk("q5_busy", busy2, 1);
    for (int c = 7; c >= 0; c--) begin
      re2 = 1; rc2 = 3'(c); req2 = 1; exp_q2.push_back({32{5'(c + 3)}});
      tick();
    end
    re2 = 0; req2 = 0;
    fd2 = 1; tick(); fd2 = 0;
    chk("q5_rd_bank", rb2, 1);
    chk("q5_busy_released", busy2, 0);

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
